// File: rtl/jtframe_sdram_share_pkg.sv
// Shared definitions for the SDRAM bank arbiter: FSM state encodings and sizing helpers.
package jtframe_sdram_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Channel index width; a single channel still needs a one-bit index.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_sdram_share_prio.sv
// Priority picker: one-hot winner among requests, either lowest index first or
// rotating from a start pointer.
module jtframe_rr_prio
  import jtframe_sdram_share_pkg::*;
#(
  parameter int NCH = 2,
  parameter int RR  = 0,
  parameter int PW  = 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [PW-1:0]  idx_o
);

  int   pos;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < NCH; i++) begin
      pos = ((RR != 0) ? int'(ptr_i) : 0) + i;
      if (pos >= NCH) pos = pos - NCH;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram_share.sv
// N-way SDRAM bank arbiter: grants one requester at a time, passes its request to
// the controller bank port, routes the handshake back and aborts stuck transactions.
module jtframe_sdram_share
  import jtframe_sdram_share_pkg::*;
#(
  parameter int AW  = 22,
  parameter int NCH = 2,
  parameter int RR  = 0,
  parameter int TOW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH-1:0]    ch_rd,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [NCH*16-1:0] ch_din,
  input  logic [NCH*2-1:0]  ch_din_m,
  output logic [NCH-1:0]    ch_ack,
  output logic [NCH-1:0]    ch_dst,
  output logic [NCH-1:0]    ch_rdy,
  output logic [NCH-1:0]    ch_tout,
  output logic [AW-1:0]     ba_addr,
  output logic              ba_rd,
  output logic              ba_wr,
  output logic [15:0]       ba_din,
  output logic [1:0]        ba_din_m,
  input  logic              ba_ack,
  input  logic              ba_dst,
  input  logic              ba_rdy,
  output logic [NCH-1:0]    owner,
  output logic              busy
);

  localparam int             PW      = ptr_w(NCH);
  localparam logic [TOW-1:0] CNT_MAX = '1;
  localparam logic [TOW-1:0] CNT_LIM = CNT_MAX - 1'b1;

  state_t           st_q;
  logic [NCH-1:0]   owner_q;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [TOW-1:0]   cnt_q;
  logic [NCH-1:0]   tout_q;

  logic [NCH-1:0]   req, win;
  logic [PW-1:0]    win_idx;
  logic             active;
  logic [AW-1:0]    mux_addr;
  logic [15:0]      mux_din;
  logic [1:0]       mux_dm;

  assign req = ch_rd | ch_wr;

  jtframe_rr_prio #(.NCH(NCH), .RR(RR), .PW(PW)) u_prio (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win),
    .idx_o (win_idx)
  );

  assign ptr_d = (win_idx == PW'(NCH-1)) ? '0 : win_idx + 1'b1;

  // owner_q is one-hot, so an AND-OR mux is enough and follows it in every state
  always_comb begin
    mux_addr = '0;
    mux_din  = '0;
    mux_dm   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (owner_q[k]) begin
        mux_addr = mux_addr | ch_addr[k*AW +: AW];
        mux_din  = mux_din  | ch_din[k*16 +: 16];
        mux_dm   = mux_dm   | ch_din_m[k*2 +: 2];
      end
    end
  end

  assign active   = (st_q != ST_IDLE);
  assign ba_addr  = mux_addr;
  assign ba_din   = mux_din;
  assign ba_din_m = mux_dm;
  assign ba_rd    = (st_q == ST_REQ) & |(owner_q & ch_rd);
  assign ba_wr    = (st_q == ST_REQ) & |(owner_q & ch_wr);
  assign ch_ack   = owner_q & {NCH{ba_ack & active}};
  assign ch_dst   = owner_q & {NCH{ba_dst & active}};
  assign ch_rdy   = owner_q & {NCH{ba_rdy & active}};
  assign ch_tout  = tout_q;
  assign owner    = owner_q;
  assign busy     = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      owner_q <= NCH'(1);
      ptr_q   <= '0;
      cnt_q   <= '0;
      tout_q  <= '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (|req) begin
            owner_q <= win;
            st_q    <= ST_REQ;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
          end
        end
        default: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          // completion beats the timeout when both land on the same cycle
          if (ba_rdy) begin
            st_q <= ST_IDLE;
          end else if (cnt_q >= CNT_LIM) begin
            st_q   <= ST_IDLE;
            tout_q <= tout_q | owner_q;
          end else if (st_q == ST_REQ && ba_ack) begin
            st_q <= ST_WAIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_share.sv
// Directed bench: a 2-channel fixed-priority arbiter and a 3-channel round-robin one
// with a short timeout, driven by hand-written controller handshakes.
module tb_jtframe_sdram_share;
  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: NCH=2, fixed priority
  logic [2*AW-1:0] a_addr;
  logic [1:0]      a_rd, a_wr, a_ack, a_dst, a_rdy, a_tout, a_owner;
  logic [31:0]     a_din;
  logic [3:0]      a_dm;
  logic [AW-1:0]   a_ba_addr;
  logic            a_ba_rd, a_ba_wr, a_busy;
  logic [15:0]     a_ba_din;
  logic [1:0]      a_ba_dm;
  logic            a_ba_ack, a_ba_dst, a_ba_rdy;

  // instance B: NCH=3, round-robin, TOW=4
  logic [3*AW-1:0] b_addr;
  logic [2:0]      b_rd, b_wr, b_ack, b_dst, b_rdy, b_tout, b_owner;
  logic [47:0]     b_din;
  logic [5:0]      b_dm;
  logic [AW-1:0]   b_ba_addr;
  logic            b_ba_rd, b_ba_wr, b_busy;
  logic [15:0]     b_ba_din;
  logic [1:0]      b_ba_dm;
  logic            b_ba_ack, b_ba_dst, b_ba_rdy;

  jtframe_sdram_share #(.AW(AW), .NCH(2), .RR(0), .TOW(10)) u_a (
    .clk(clk), .rst(rst),
    .ch_addr(a_addr), .ch_rd(a_rd), .ch_wr(a_wr), .ch_din(a_din), .ch_din_m(a_dm),
    .ch_ack(a_ack), .ch_dst(a_dst), .ch_rdy(a_rdy), .ch_tout(a_tout),
    .ba_addr(a_ba_addr), .ba_rd(a_ba_rd), .ba_wr(a_ba_wr), .ba_din(a_ba_din),
    .ba_din_m(a_ba_dm), .ba_ack(a_ba_ack), .ba_dst(a_ba_dst), .ba_rdy(a_ba_rdy),
    .owner(a_owner), .busy(a_busy)
  );

  jtframe_sdram_share #(.AW(AW), .NCH(3), .RR(1), .TOW(4)) u_b (
    .clk(clk), .rst(rst),
    .ch_addr(b_addr), .ch_rd(b_rd), .ch_wr(b_wr), .ch_din(b_din), .ch_din_m(b_dm),
    .ch_ack(b_ack), .ch_dst(b_dst), .ch_rdy(b_rdy), .ch_tout(b_tout),
    .ba_addr(b_ba_addr), .ba_rd(b_ba_rd), .ba_wr(b_ba_wr), .ba_din(b_ba_din),
    .ba_din_m(b_ba_dm), .ba_ack(b_ba_ack), .ba_dst(b_ba_dst), .ba_rdy(b_ba_rdy),
    .owner(b_owner), .busy(b_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int exp_seq [6] = '{1, 2, 4, 1, 2, 4};

  initial begin
    a_addr = {22'd200, 22'd100}; a_rd = '0; a_wr = '0;
    a_din = {16'h2222, 16'h1111}; a_dm = 4'b0000;
    a_ba_ack = 0; a_ba_dst = 0; a_ba_rdy = 0;
    b_addr = {22'd3, 22'd2, 22'd1}; b_rd = '0; b_wr = '0; b_din = '0; b_dm = '0;
    b_ba_ack = 0; b_ba_dst = 0; b_ba_rdy = 0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_owner_a", a_owner, 2'b01);
    chk("rst_busy_a", a_busy, 0);
    chk("rst_bard_a", a_ba_rd, 0);
    chk("rst_tout_b", b_tout, 0);
    chk("rst_owner_b", b_owner, 3'b001);

    // fixed priority: both channels request together
    a_rd = 2'b11; #1;
    chk("t1_idle_bard", a_ba_rd, 0);
    tick;
    chk("t1_owner0", a_owner, 2'b01);
    chk("t1_bard", a_ba_rd, 1);
    chk("t1_addr0", a_ba_addr, 100);
    a_ba_ack = 1; #1;
    chk("t1_ack0", a_ack, 2'b01);
    tick;
    a_ba_ack = 0; a_rd[0] = 0; a_ba_dst = 1; #1;
    chk("t1_wait_bard", a_ba_rd, 0);
    chk("t1_dst0", a_dst, 2'b01);
    a_ba_dst = 0; a_ba_rdy = 1; #1;
    chk("t1_rdy0", a_rdy, 2'b01);
    tick;
    a_ba_rdy = 0; #1;
    chk("t1_idle_gap_busy", a_busy, 0);
    chk("t1_idle_gap_bard", a_ba_rd, 0);
    tick;
    chk("t1_owner1", a_owner, 2'b10);
    chk("t1_addr1", a_ba_addr, 200);
    // ack and rdy together finish straight away
    a_ba_ack = 1; a_ba_rdy = 1; #1;
    chk("t6_ack1", a_ack, 2'b10);
    chk("t6_rdy1", a_rdy, 2'b10);
    tick;
    a_ba_ack = 0; a_ba_rdy = 0; a_rd = 0; #1;
    chk("t6_idle", a_busy, 0);
    chk("t6_no_2nd_rdy", a_rdy, 0);

    // write from channel 1 with field routing
    a_addr = {22'h3_0000, 22'd100}; a_din = {16'hA55A, 16'h1111}; a_dm = {2'b01, 2'b10};
    a_wr = 2'b10;
    tick;
    chk("t3_owner", a_owner, 2'b10);
    chk("t3_bawr", a_ba_wr, 1);
    chk("t3_bard", a_ba_rd, 0);
    chk("t3_addr", a_ba_addr, 32'h3_0000);
    chk("t3_din", a_ba_din, 16'hA55A);
    chk("t3_dm", a_ba_dm, 2'b01);
    a_ba_ack = 1; #1;
    chk("t3_ack", a_ack, 2'b10);
    tick;
    a_ba_ack = 0; a_wr = 0; a_ba_rdy = 1; #1;
    chk("t3_rdy", a_rdy, 2'b10);
    tick;
    a_ba_rdy = 0;

    // reset while waiting for completion
    a_rd = 2'b10;
    tick;
    a_ba_ack = 1;
    tick;
    a_ba_ack = 0; a_rd = 0; #1;
    chk("t5_in_wait", a_busy, 1);
    rst = 1;
    tick;
    rst = 0; #1;
    chk("t5_owner", a_owner, 2'b01);
    chk("t5_busy", a_busy, 0);
    tick;
    a_ba_rdy = 1; #1;
    chk("t5_no_rdy", a_rdy, 0);
    tick;
    a_ba_rdy = 0;

    // round-robin with all channels held
    b_rd = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("t2_owner", b_owner, exp_seq[i]);
      chk("t2_bard", b_ba_rd, 1);
      b_ba_ack = 1; #1;
      chk("t2_ack", b_ack, exp_seq[i]);
      tick;
      b_ba_ack = 0; b_ba_rdy = 1;
      tick;
      b_ba_rdy = 0;
      if (i == 5) b_rd = 0;
    end

    // timeout: ch0 never completes
    #1;
    b_rd = 3'b001;
    tick;
    b_rd = 0;
    for (int k = 1; k <= 15; k++) begin
      chk("t4_busy", b_busy, 1);
      tick;
    end
    chk("t4_abort_busy", b_busy, 0);
    chk("t4_tout", b_tout, 3'b001);

    // completion arrives on the last allowed cycle
    b_rd = 3'b010;
    tick;
    b_rd = 0;
    for (int k = 1; k <= 14; k++) tick;
    chk("t4b_still_busy", b_busy, 1);
    b_ba_rdy = 1; #1;
    chk("t4b_rdy", b_rdy, 3'b010);
    tick;
    b_ba_rdy = 0; #1;
    chk("t4b_idle", b_busy, 0);
    chk("t4b_tout", b_tout, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
